// File: rtl/vrased_reset_ctrl.sv
// Security-monitor reset responder: stretches core reset, optionally zero-wipes a RAM window,
// then releases the core. Build with VRASED_RST_WIPE_EN defined to include the wipe engine.
module vrased_reset_ctrl #(
    parameter logic [15:0] WIPE_BASE  = 16'h0200,
    parameter logic [15:0] WIPE_WORDS = 16'd256,
    parameter logic [7:0]  STRETCH    = 8'd8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        viol_req,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [15:0] mem_addr,
    output logic        mem_wen,
    output logic [15:0] mem_dout,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic [7:0]  viol_cnt
);

    typedef enum logic [1:0] {IDLE, HOLD, WIPE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [7:0]  viol_cnt_nxt;
    logic        viol_q;
    logic        done_nxt;
    logic        rise;

    assign rise     = viol_req & ~viol_q;
    assign mem_wen  = mem_req;
    assign mem_dout = 16'h0000;

`ifdef VRASED_RST_WIPE_EN
    logic [15:0] idx, idx_nxt;
    logic [15:0] addr_nxt;
    logic        req_nxt;
`else
    logic unused_cfg;
    assign unused_cfg = mem_gnt ^ (WIPE_WORDS == 16'd0);
    assign mem_req    = 1'b0;
    assign mem_addr   = WIPE_BASE;
`endif

    // Reset lands in HOLD so every power-on runs a full stretch (and wipe).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HOLD;
            cnt      <= STRETCH - 8'd1;
            viol_q   <= 1'b0;
            core_rst <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            viol_cnt <= 8'h00;
`ifdef VRASED_RST_WIPE_EN
            mem_req  <= 1'b0;
            mem_addr <= WIPE_BASE;
            idx      <= 16'h0000;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            viol_q   <= viol_req;
            core_rst <= (state_nxt != IDLE);
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            viol_cnt <= viol_cnt_nxt;
`ifdef VRASED_RST_WIPE_EN
            mem_req  <= req_nxt;
            mem_addr <= addr_nxt;
            idx      <= idx_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        done_nxt     = 1'b0;
        viol_cnt_nxt = viol_cnt;
`ifdef VRASED_RST_WIPE_EN
        req_nxt      = mem_req;
        addr_nxt     = mem_addr;
        idx_nxt      = idx;
`endif
        case (state)
            IDLE: begin
                if (viol_req) begin
                    state_nxt    = HOLD;
                    cnt_nxt      = STRETCH - 8'd1;
                    viol_cnt_nxt = (viol_cnt == 8'hFF) ? viol_cnt : viol_cnt + 8'd1;
                end
            end
            HOLD: begin
                // A fresh request restarts the minimum hold time.
                if (rise) begin
                    cnt_nxt = STRETCH - 8'd1;
                end else if (cnt == 8'd0) begin
`ifdef VRASED_RST_WIPE_EN
                    state_nxt = WIPE;
                    req_nxt   = 1'b1;
                    addr_nxt  = WIPE_BASE;
                    idx_nxt   = 16'h0000;
`else
                    state_nxt = WAIT;
`endif
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
`ifdef VRASED_RST_WIPE_EN
            WIPE: begin
                if (mem_gnt) begin
                    addr_nxt = mem_addr + 16'd2;
                    idx_nxt  = idx + 16'd1;
                    if (idx == WIPE_WORDS - 16'd1) begin
                        req_nxt   = 1'b0;
                        state_nxt = WAIT;
                    end
                end
            end
`endif
            WAIT: begin
                if (rise) begin
                    state_nxt = HOLD;
                    cnt_nxt   = STRETCH - 8'd1;
                end else if (!viol_req) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = STRETCH - 8'd1;
            end
        endcase
    end

endmodule

// File: doc/vrased_reset_ctrl.md
Name: vrased_reset_ctrl

Overview:
- Responder side of the security-monitor reset request.
- Consumes the level reset request (`viol_req`) driven by the PoR/access monitors.
- Holds the openMSP430 core in reset for a minimum stretch, then zero-wipes a protected RAM window through a request/grant write port.
- Releases the core only after the wipe completes and the request has dropped; sits between the monitors and the core reset input.

Parameters:
- WIPE_BASE, 16'h0200, byte address of first word to erase (word aligned)
- WIPE_WORDS, 16'd256, number of 16-bit words erased (must be >= 1)
- STRETCH, 8'd8, minimum cycles core reset is held before wiping (must be >= 1)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- viol_req  input  1  level reset request from monitors, high = reset required
- mem_req  output  1  wipe write request
- mem_gnt  input  1  write accepted this cycle (sampled only while mem_req=1)
- mem_addr  output  16  wipe write byte address
- mem_wen  output  1  write enable, equals mem_req
- mem_dout  output  16  write data, constant 16'h0000
- core_rst  output  1  active-high reset to core
- busy  output  1  high in any state other than IDLE
- done  output  1  single-cycle pulse on the HOLD/WIPE/WAIT -> IDLE transition
- viol_cnt  output  8  saturating count of IDLE->HOLD entries

Behaviour:
- All outputs are registered. Single clock; reset_n is asynchronous active-low.
- Reset values:
  - state = HOLD, stretch counter = STRETCH-1, core_rst=1, busy=1
  - mem_req=0, mem_addr=WIPE_BASE, done=0, viol_cnt=0
  - Consequence: every power-on performs a full stretch and wipe.
- FSM states: IDLE, HOLD, WIPE, WAIT.
- IDLE:
  - core_rst=0.
  - viol_req=1 -> HOLD next cycle; core_rst=1 on that same edge; counter=STRETCH-1; viol_cnt+1, saturating at 8'hFF.
- HOLD:
  - Counter decrements each cycle.
  - A viol_req 0->1 edge (edge-detect register) reloads the counter to STRETCH-1.
  - Counter==0 -> WIPE; mem_addr=WIPE_BASE; word index=0; mem_req=1 on entry.
  - Minimum HOLD residency = STRETCH cycles.
- WIPE:
  - mem_req held high until the last write is granted.
  - Address and data stay stable while mem_gnt=0.
  - On mem_gnt: mem_addr += 2 (16-bit wrap, no carry out); index += 1.
  - On grant of index WIPE_WORDS-1: mem_req=0 next cycle, -> WAIT.
  - viol_req activity during WIPE is ignored; the wipe always runs to completion.
- WAIT:
  - viol_req=0 -> IDLE: core_rst=0 and done=1 on the same edge.
  - viol_req=1 -> stay in WAIT with core_rst held.
  - A viol_req 0->1 edge in WAIT -> HOLD, counter reloaded, full wipe repeated.
- Throughput: one word per granted cycle. With mem_gnt tied high, minimum assert-to-release = 1 + STRETCH + WIPE_WORDS + 1 cycles.
- reset_n assertion mid-wipe aborts immediately to reset values (mem_req=0). The wipe then restarts from WIPE_BASE after reset_n deasserts.
- core_rst never deasserts except on the WAIT->IDLE edge.
- viol_cnt is not affected by retriggers within HOLD/WAIT.

Optional Feature:
- Macro: VRASED_RST_WIPE_EN.
- Defined: behaviour as above.
- Undefined:
  - WIPE state is not built; HOLD counter==0 goes directly to WAIT.
  - mem_req/mem_wen tied 0; mem_addr tied WIPE_BASE.
  - Release latency = STRETCH + 1 cycles after viol_req drops, measured from HOLD entry.

Test Plan:
- Power-on: reset_n low 3 cycles then high, viol_req=0, mem_gnt=1, defaults.
  - core_rst=1 for 1 + 8 + 256 + 1 cycles.
  - 256 writes at 0x0200..0x03FE, data 0.
  - done pulses once; viol_cnt=0.
- Backpressure: mem_gnt toggles 1,0,1,0 during WIPE.
  - mem_addr stable across each gnt=0 cycle.
  - Exactly 256 grants observed; no address skipped or repeated.
- Retrigger in HOLD: viol_req pulses 0->1 at HOLD counter=3.
  - Counter reloads to 7.
  - First mem_req appears 8 cycles after the retrigger edge.
- Held request: viol_req stays 1 for 20 cycles after wipe completes.
  - core_rst stays 1 and busy=1 throughout.
  - Release and done occur on the edge after viol_req falls.
- Mid-wipe reset: reset_n pulsed low at word index 100.
  - mem_req drops asynchronously.
  - After release, writes restart at 0x0200 and 256 writes complete.
- Counter saturation: 300 IDLE->HOLD entries with WIPE_WORDS=1 and STRETCH=1.
  - viol_cnt stops at 8'hFF.
  - With VRASED_RST_WIPE_EN undefined, mem_req never asserts.
